// File: rtl/noc_packet_types_pkg.sv
// Shared NoC packet definitions: packet/status/flit type encodings, width helpers
// and the has_payload rule used by the packet unpacker.
//
// Header placement inside the flit data field: the common header always occupies
// the top COMMON bits of a header region that is max(address, response fields)
// wide. Requests put the address in the low bits of that region and responses put
// {status, lower_address, last_response} there, so packet_type sits at a fixed bit
// position and the packet kind can be decoded before the rest of the layout is known.
package noc_packet_types_pkg;

  typedef enum logic [7:0] {
    PKT_READ               = 8'h00,
    PKT_POSTED_WRITE       = 8'h40,
    PKT_NON_POSTED_WRITE   = 8'h60,
    PKT_RESPONSE           = 8'h80,
    PKT_RESPONSE_WITH_DATA = 8'hC0
  } packet_type_e;

  typedef enum logic [1:0] {
    STATUS_OKAY   = 2'd0,
    STATUS_EXOKAY = 2'd1,
    STATUS_SLVERR = 2'd2,
    STATUS_DECERR = 2'd3
  } response_status_e;

  typedef enum logic {
    FLIT_HEADER  = 1'b0,
    FLIT_PAYLOAD = 1'b1
  } flit_type_e;

  localparam int PACKET_TYPE_WIDTH = 8;
  localparam int STATUS_WIDTH      = 2;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int common_header_width(int id_x_w, int id_y_w, int tag_w, int len_w);
    return PACKET_TYPE_WIDTH + 2 * (id_x_w + id_y_w) + tag_w + len_w;
  endfunction

  function automatic int response_field_width(int data_w);
    return STATUS_WIDTH + $clog2(data_w / 8) + 1;
  endfunction

  function automatic int header_width(int common_w, int address_w, int data_w);
    return common_w + max_int(address_w, response_field_width(data_w));
  endfunction

  function automatic int payload_width(int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int flit_width(int header_w, int payload_w);
    return 2 + max_int(header_w, payload_w);
  endfunction

  function automatic logic has_payload(logic [PACKET_TYPE_WIDTH-1:0] packet_type);
    return packet_type[6];
  endfunction

endpackage

// File: rtl/noc_packet_unpacker_slice.sv
// Single-entry valid/ready output register; accepts a new entry whenever it is
// empty or its current entry is being taken in the same cycle.
module noc_packet_unpacker_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Load on input handshake, otherwise drain on output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_packet_unpacker.sv
// NoC endpoint receive stage: splits the flit stream into a header-field output and
// a payload beat output, dropping malformed packets and pulsing o_error.
// Optional macro NOC_PACKET_UNPACKER_LENGTH_CHECK_EN adds a beat counter that flags
// packets whose beat count differs from the header length field.
//
// state      | meaning
// ST_IDLE    | waiting for a header flit
// ST_PAYLOAD | forwarding payload beats until the tail flit
// ST_DROP    | discarding a malformed packet until its tail flit
module noc_packet_unpacker
  import noc_packet_types_pkg::*;
#(
  parameter int ID_X_WIDTH    = 4,
  parameter int ID_Y_WIDTH    = 4,
  parameter int TAG_WIDTH     = 8,
  parameter int LENGTH_WIDTH  = 8,
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 256,
  localparam int ID_WIDTH      = ID_X_WIDTH + ID_Y_WIDTH,
  localparam int BE_WIDTH      = DATA_WIDTH / 8,
  localparam int LOWER_WIDTH   = $clog2(BE_WIDTH),
  localparam int COMMON_WIDTH  = common_header_width(ID_X_WIDTH, ID_Y_WIDTH, TAG_WIDTH, LENGTH_WIDTH),
  localparam int HEADER_WIDTH  = header_width(COMMON_WIDTH, ADDRESS_WIDTH, DATA_WIDTH),
  localparam int PAYLOAD_WIDTH = payload_width(DATA_WIDTH),
  localparam int FLIT_WIDTH    = flit_width(HEADER_WIDTH, PAYLOAD_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flit_valid,
  output logic                         o_flit_ready,
  input  logic [FLIT_WIDTH-1:0]        i_flit,
  output logic                         o_header_valid,
  input  logic                         i_header_ready,
  output logic [PACKET_TYPE_WIDTH-1:0] o_packet_type,
  output logic [ID_WIDTH-1:0]          o_destination_id,
  output logic [ID_WIDTH-1:0]          o_source_id,
  output logic [TAG_WIDTH-1:0]         o_tag,
  output logic [LENGTH_WIDTH-1:0]      o_length,
  output logic [ADDRESS_WIDTH-1:0]     o_address,
  output logic [STATUS_WIDTH-1:0]      o_response_status,
  output logic [LOWER_WIDTH-1:0]       o_lower_address,
  output logic                         o_last_response,
  output logic                         o_payload_valid,
  input  logic                         i_payload_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [BE_WIDTH-1:0]          o_byte_enable,
  output logic                         o_payload_last,
  output logic                         o_error
);

  localparam int RESP_WIDTH     = response_field_width(DATA_WIDTH);
  localparam int HDR_REG_WIDTH  = PACKET_TYPE_WIDTH + 2 * ID_WIDTH + TAG_WIDTH + LENGTH_WIDTH
                                + ADDRESS_WIDTH + STATUS_WIDTH + LOWER_WIDTH + 1;
  localparam int BEAT_REG_WIDTH = PAYLOAD_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  state_e state;

  logic                         flit_is_header;
  logic                         flit_tail;
  logic [FLIT_WIDTH-3:0]        flit_data;
  logic [PACKET_TYPE_WIDTH-1:0] hdr_type;
  logic [ID_WIDTH-1:0]          hdr_dst;
  logic [ID_WIDTH-1:0]          hdr_src;
  logic [TAG_WIDTH-1:0]         hdr_tag;
  logic [LENGTH_WIDTH-1:0]      hdr_len;
  logic                         hdr_is_response;
  logic [ADDRESS_WIDTH-1:0]     hdr_address;
  logic [STATUS_WIDTH-1:0]      hdr_status;
  logic [LOWER_WIDTH-1:0]       hdr_lower;
  logic                         hdr_last;
  logic                         header_ok;
  logic                         flit_accept;
  logic                         hdr_load;
  logic                         beat_load;
  logic                         hdr_in_ready;
  logic                         beat_in_ready;
  logic                         flit_error;
  logic                         length_error;

  assign flit_is_header = (i_flit[FLIT_WIDTH-1] == FLIT_HEADER);
  assign flit_tail      = i_flit[FLIT_WIDTH-2];
  assign flit_data      = i_flit[FLIT_WIDTH-3:0];

  assign {hdr_type, hdr_dst, hdr_src, hdr_tag, hdr_len} = flit_data[HEADER_WIDTH-1 -: COMMON_WIDTH];
  assign hdr_is_response = hdr_type[7];
  assign hdr_address     = hdr_is_response ? '0 : flit_data[ADDRESS_WIDTH-1:0];
  assign hdr_status      = hdr_is_response ? flit_data[RESP_WIDTH-1 -: STATUS_WIDTH] : '0;
  assign hdr_lower       = hdr_is_response ? flit_data[LOWER_WIDTH:1] : '0;
  assign hdr_last        = hdr_is_response & flit_data[0];
  assign header_ok       = (flit_tail == !has_payload(hdr_type));

  // Only flits that are forwarded wait on an output register; dropped flits always pass.
  always_comb begin
    o_flit_ready = 1'b1;
    case (state)
      ST_IDLE:    if (flit_is_header && header_ok) o_flit_ready = hdr_in_ready;
      ST_PAYLOAD: if (!flit_is_header) o_flit_ready = beat_in_ready;
      default:    o_flit_ready = 1'b1;
    endcase
  end

  assign flit_accept = i_flit_valid && o_flit_ready;
  assign hdr_load    = flit_accept && (state == ST_IDLE) && flit_is_header && header_ok;
  assign beat_load   = flit_accept && (state == ST_PAYLOAD) && !flit_is_header;
  assign flit_error  = flit_accept && (((state == ST_IDLE) && !(flit_is_header && header_ok))
                                    || ((state == ST_PAYLOAD) && flit_is_header));

`ifdef NOC_PACKET_UNPACKER_LENGTH_CHECK_EN
  logic [LENGTH_WIDTH:0] beat_count;
  logic [LENGTH_WIDTH:0] expected_count;

  assign length_error = beat_load && flit_tail
                        && ((beat_count + (LENGTH_WIDTH + 1)'(1)) != expected_count);
`else
  assign length_error = 1'b0;
`endif

  // Packet framing state, error pulse and (optionally) beat counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      o_error <= 1'b0;
`ifdef NOC_PACKET_UNPACKER_LENGTH_CHECK_EN
      beat_count     <= '0;
      expected_count <= '0;
`endif
    end else begin
      o_error <= flit_error || length_error;
`ifdef NOC_PACKET_UNPACKER_LENGTH_CHECK_EN
      if (hdr_load) begin
        beat_count     <= '0;
        expected_count <= {(hdr_len == '0), hdr_len};
      end else if (beat_load) begin
        beat_count <= beat_count + (LENGTH_WIDTH + 1)'(1);
      end
`endif
      if (flit_accept) begin
        case (state)
          ST_IDLE: begin
            if (flit_is_header) begin
              if (header_ok) begin
                if (has_payload(hdr_type)) state <= ST_PAYLOAD;
              end else if (!flit_tail) begin
                state <= ST_DROP;
              end
            end
          end
          ST_PAYLOAD: if (!flit_is_header && flit_tail) state <= ST_IDLE;
          ST_DROP:    if (flit_tail) state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  noc_packet_unpacker_slice #(.WIDTH(HDR_REG_WIDTH)) u_header_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hdr_load),
    .in_ready  (hdr_in_ready),
    .in_data   ({hdr_type, hdr_dst, hdr_src, hdr_tag, hdr_len,
                 hdr_address, hdr_status, hdr_lower, hdr_last}),
    .out_valid (o_header_valid),
    .out_ready (i_header_ready),
    .out_data  ({o_packet_type, o_destination_id, o_source_id, o_tag, o_length,
                 o_address, o_response_status, o_lower_address, o_last_response})
  );

  noc_packet_unpacker_slice #(.WIDTH(BEAT_REG_WIDTH)) u_payload_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (beat_load),
    .in_ready  (beat_in_ready),
    .in_data   ({flit_tail, flit_data[PAYLOAD_WIDTH-1:0]}),
    .out_valid (o_payload_valid),
    .out_ready (i_payload_ready),
    .out_data  ({o_payload_last, o_data, o_byte_enable})
  );

endmodule

// File: tb/tb_noc_packet_unpacker.sv
// Directed bench for noc_packet_unpacker (default parameters) with a packet-level
// reference model and per-cycle output comparison.
module tb_noc_packet_unpacker;
  import noc_packet_types_pkg::*;

  localparam int FW = 290;
`ifdef NOC_PACKET_UNPACKER_LENGTH_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  ptype;
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [7:0]  tag;
    logic [7:0]  len;
    logic [63:0] addr;
    logic [1:0]  status;
    logic [4:0]  lower;
    logic        last;
  } hdr_t;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  be;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flit_valid;
  logic          o_flit_ready;
  logic [FW-1:0] i_flit;
  logic          o_header_valid;
  logic          i_header_ready;
  logic [7:0]    o_packet_type;
  logic [7:0]    o_destination_id;
  logic [7:0]    o_source_id;
  logic [7:0]    o_tag;
  logic [7:0]    o_length;
  logic [63:0]   o_address;
  logic [1:0]    o_response_status;
  logic [4:0]    o_lower_address;
  logic          o_last_response;
  logic          o_payload_valid;
  logic          i_payload_ready;
  logic [255:0]  o_data;
  logic [31:0]   o_byte_enable;
  logic          o_payload_last;
  logic          o_error;

  always #5 clk = ~clk;

  noc_packet_unpacker dut (
    .clk(clk), .rst(rst),
    .i_flit_valid(i_flit_valid), .o_flit_ready(o_flit_ready), .i_flit(i_flit),
    .o_header_valid(o_header_valid), .i_header_ready(i_header_ready),
    .o_packet_type(o_packet_type), .o_destination_id(o_destination_id),
    .o_source_id(o_source_id), .o_tag(o_tag), .o_length(o_length),
    .o_address(o_address), .o_response_status(o_response_status),
    .o_lower_address(o_lower_address), .o_last_response(o_last_response),
    .o_payload_valid(o_payload_valid), .i_payload_ready(i_payload_ready),
    .o_data(o_data), .o_byte_enable(o_byte_enable), .o_payload_last(o_payload_last),
    .o_error(o_error)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(string name, logic [299:0] act, logic [299:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic  drv_is_header = 1'b1;
  logic  drv_tail = 1'b0;
  hdr_t  drv_hdr = '0;
  beat_t drv_beat = '0;
  int    last_wait;

  function automatic hdr_t mk_hdr(logic [7:0] ptype, logic [7:0] tag, logic [7:0] len,
                                  logic [63:0] addr, logic [1:0] status, logic [4:0] lower,
                                  logic last);
    hdr_t h;
    h.ptype = ptype; h.dst = 8'h23; h.src = 8'h45; h.tag = tag; h.len = len;
    h.addr = addr; h.status = status; h.lower = lower; h.last = last;
    return h;
  endfunction

  function automatic logic [FW-1:0] header_flit(hdr_t h, logic tail);
    logic [287:0] d;
    d = '0;
    d[103:64] = {h.ptype, h.dst, h.src, h.tag, h.len};
    if (h.ptype[7]) d[7:0] = {h.status, h.lower, h.last};
    else            d[63:0] = h.addr;
    return {1'b0, tail, d};
  endfunction

  task automatic drive_header(hdr_t h, logic tail);
    drv_is_header = 1'b1; drv_tail = tail; drv_hdr = h;
    i_flit = header_flit(h, tail);
    i_flit_valid = 1'b1;
  endtask

  task automatic drive_beat(logic [255:0] data, logic [31:0] be, logic tail);
    drv_is_header = 1'b0; drv_tail = tail; drv_beat = {data, be, tail};
    i_flit = {1'b1, tail, data, be};
    i_flit_valid = 1'b1;
  endtask

  task automatic wait_accept(string name);
    bit done;
    done = 1'b0;
    last_wait = 0;
    while (!done) begin
      @(negedge clk);
      if (o_flit_ready) done = 1'b1;
      @(posedge clk); #1;
      if (!done) begin
        last_wait++;
        if (last_wait > 40) begin
          tests_run++; tests_failed++;
          $display("FAIL %s: flit not accepted within 40 cycles", name);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_header(hdr_t h, logic tail, string name);
    drive_header(h, tail);
    wait_accept(name);
  endtask

  task automatic send_beat(logic [255:0] data, logic [31:0] be, logic tail, string name);
    drive_beat(data, be, tail);
    wait_accept(name);
  endtask

  task automatic idle(int n);
    i_flit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  hdr_t  hdr_q[$];
  beat_t beat_q[$];
  logic  exp_err;
  bit    in_pkt, discarding;
  int    beats_in_pkt, pkt_len;
  int    err_seen = 0, hdr_seen = 0, beat_seen = 0;
  beat_t last_beat = '0;

  function automatic bit carries_payload(logic [7:0] t);
    return (t == 8'h40) || (t == 8'h60) || (t == 8'hC0);
  endfunction

  function automatic hdr_t expected_header(hdr_t h);
    hdr_t e;
    e = h;
    if (h.ptype[7]) e.addr = '0;
    else begin e.status = '0; e.lower = '0; e.last = 1'b0; end
    return e;
  endfunction

  // Compare outputs each cycle, then fold the flit accepted at the coming edge into the model.
  always @(negedge clk) begin
    if (rst) begin
      hdr_q.delete(); beat_q.delete();
      exp_err = 1'b0; in_pkt = 0; discarding = 0; beats_in_pkt = 0; pkt_len = 0;
    end else begin
      check("error_pulse", o_error, exp_err);
      if (o_error) err_seen++;
      check("header_valid", o_header_valid, hdr_q.size() != 0);
      if (o_header_valid && hdr_q.size() != 0) begin
        check("header_fields", {o_packet_type, o_destination_id, o_source_id, o_tag, o_length,
              o_address, o_response_status, o_lower_address, o_last_response}, hdr_q[0]);
        if (i_header_ready) begin void'(hdr_q.pop_front()); hdr_seen++; end
      end
      check("payload_valid", o_payload_valid, beat_q.size() != 0);
      if (o_payload_valid && beat_q.size() != 0) begin
        check("payload_beat", {o_data, o_byte_enable, o_payload_last}, beat_q[0]);
        if (i_payload_ready) begin
          void'(beat_q.pop_front()); beat_seen++;
          last_beat = {o_data, o_byte_enable, o_payload_last};
        end
      end
      exp_err = 1'b0;
      if (i_flit_valid && o_flit_ready) begin
        if (discarding) begin
          if (drv_tail) discarding = 0;
        end else if (in_pkt) begin
          if (drv_is_header) exp_err = 1'b1;
          else begin
            beat_q.push_back(drv_beat);
            beats_in_pkt++;
            if (drv_tail) begin
              in_pkt = 0;
              if (LEN_CHECK && beats_in_pkt != pkt_len) exp_err = 1'b1;
            end
          end
        end else if (!drv_is_header) begin
          exp_err = 1'b1;
        end else if (drv_tail != carries_payload(drv_hdr.ptype)) begin
          hdr_q.push_back(expected_header(drv_hdr));
          if (!drv_tail) begin
            in_pkt = 1; beats_in_pkt = 0;
            pkt_len = (drv_hdr.len == 8'd0) ? 256 : int'(drv_hdr.len);
          end
        end else begin
          exp_err = 1'b1;
          if (!drv_tail) discarding = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int e0, h0, b0;
    rst = 1'b1;
    i_flit_valid = 1'b0; i_flit = '0;
    i_header_ready = 1'b1; i_payload_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_header_valid", o_header_valid, 1'b0);
    check("reset_payload_valid", o_payload_valid, 1'b0);
    check("reset_error", o_error, 1'b0);
    check("reset_payload_last", o_payload_last, 1'b0);
    check("reset_address", o_address, 64'h0);
    check("reset_data", o_data, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("idle_flit_ready", o_flit_ready, 1'b1);

    // T1: non-posted write, two beats
    e0 = err_seen; h0 = hdr_seen; b0 = beat_seen;
    send_header(mk_hdr(8'h60, 8'h11, 8'd2, 64'h1000_0040, 2'd0, 5'd0, 1'b0), 1'b0, "t1_hdr");
    send_beat(256'hA, 32'hFFFF_FFFF, 1'b0, "t1_beat0");
    send_beat(256'hB, 32'hFFFF_FFFF, 1'b1, "t1_beat1");
    idle(3);
    check("t1_headers", hdr_seen - h0, 1);
    check("t1_beats", beat_seen - b0, 2);
    check("t1_errors", err_seen - e0, 0);
    check("t1_last_beat", last_beat, {256'hB, 32'hFFFF_FFFF, 1'b1});

    // T2: header back-pressure holds fields and blocks the next header
    i_header_ready = 1'b0;
    send_header(mk_hdr(8'h00, 8'h21, 8'd1, 64'h1000_0040, 2'd0, 5'd0, 1'b0), 1'b1, "t2_hdr_a");
    drive_header(mk_hdr(8'h00, 8'h22, 8'd1, 64'h2000_0000, 2'd0, 5'd0, 1'b0), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", o_header_valid, 1'b1);
      check("t2_hold_address", o_address, 64'h1000_0040);
      check("t2_hold_tag", o_tag, 8'h21);
      check("t2_hold_flit_ready", o_flit_ready, 1'b0);
      @(posedge clk); #1;
    end
    i_header_ready = 1'b1;
    @(negedge clk);
    check("t2_release_flit_ready", o_flit_ready, 1'b1);
    @(posedge clk); #1;
    i_flit_valid = 1'b0;
    @(negedge clk);
    check("t2_next_tag", o_tag, 8'h22);
    check("t2_next_address", o_address, 64'h2000_0000);
    idle(2);

    // T3: payload flit while idle
    e0 = err_seen; h0 = hdr_seen; b0 = beat_seen;
    drive_beat(256'h33, 32'h1, 1'b1);
    #1 check("t3_flit_ready", o_flit_ready, 1'b1);
    wait_accept("t3_beat");
    idle(3);
    check("t3_errors", err_seen - e0, 1);
    check("t3_headers", hdr_seen - h0, 0);
    check("t3_beats", beat_seen - b0, 0);

    // T4: posted write with tail=1 is malformed; following read passes
    e0 = err_seen; h0 = hdr_seen;
    send_header(mk_hdr(8'h40, 8'h40, 8'd1, 64'h40, 2'd0, 5'd0, 1'b0), 1'b1, "t4_bad_hdr");
    send_header(mk_hdr(8'h00, 8'h41, 8'd1, 64'h1234_5678, 2'd0, 5'd0, 1'b0), 1'b1, "t4_read");
    idle(3);
    check("t4_errors", err_seen - e0, 1);
    check("t4_headers", hdr_seen - h0, 1);

    // T5: read with tail=0 drops the whole packet
    e0 = err_seen; h0 = hdr_seen; b0 = beat_seen;
    send_header(mk_hdr(8'h00, 8'h50, 8'd2, 64'h50, 2'd0, 5'd0, 1'b0), 1'b0, "t5_bad_hdr");
    send_beat(256'h51, 32'h3, 1'b0, "t5_beat0");
    drive_beat(256'h52, 32'h3, 1'b1);
    #1 check("t5_drop_flit_ready", o_flit_ready, 1'b1);
    wait_accept("t5_beat1");
    idle(3);
    check("t5_errors", err_seen - e0, 1);
    check("t5_headers", hdr_seen - h0, 0);
    check("t5_beats", beat_seen - b0, 0);
    send_header(mk_hdr(8'h00, 8'h53, 8'd1, 64'h53, 2'd0, 5'd0, 1'b0), 1'b1, "t5_read");
    idle(3);
    check("t5_back_to_idle", hdr_seen - h0, 1);

    // T6: response with data, length 3 but only 2 beats
    e0 = err_seen; h0 = hdr_seen; b0 = beat_seen;
    send_header(mk_hdr(8'hC0, 8'h60, 8'd3, 64'hDEAD, STATUS_SLVERR, 5'd5, 1'b1), 1'b0, "t6_hdr");
    send_beat(256'hC, 32'h0000_00FF, 1'b0, "t6_beat0");
    send_beat(256'hD, 32'hFF00_0000, 1'b1, "t6_beat1");
    idle(3);
    check("t6_headers", hdr_seen - h0, 1);
    check("t6_beats", beat_seen - b0, 2);
    check("t6_errors", err_seen - e0, LEN_CHECK ? 1 : 0);

    // T7: tail beat and next header back to back
    e0 = err_seen; h0 = hdr_seen; b0 = beat_seen;
    send_header(mk_hdr(8'h60, 8'h70, 8'd1, 64'h70, 2'd0, 5'd0, 1'b0), 1'b0, "t7_hdr");
    send_beat(256'h71, 32'hF, 1'b1, "t7_beat");
    check("t7_tail_no_stall", last_wait, 0);
    send_header(mk_hdr(8'h00, 8'h72, 8'd1, 64'h72, 2'd0, 5'd0, 1'b0), 1'b1, "t7_read");
    check("t7_header_no_bubble", last_wait, 0);
    idle(3);
    check("t7_headers", hdr_seen - h0, 2);
    check("t7_beats", beat_seen - b0, 1);
    check("t7_errors", err_seen - e0, 0);

    // T8: beats flow while header waits; payload back-pressure
    e0 = err_seen; h0 = hdr_seen; b0 = beat_seen;
    i_header_ready = 1'b0;
    i_payload_ready = 1'b0;
    send_header(mk_hdr(8'h60, 8'h80, 8'd3, 64'h8000, 2'd0, 5'd0, 1'b0), 1'b0, "t8_hdr");
    drive_beat(256'h81, 32'h1, 1'b0);
    #1 check("t8_first_beat_ready", o_flit_ready, 1'b1);
    wait_accept("t8_beat0");
    drive_beat(256'h82, 32'h2, 1'b0);
    #1 check("t8_full_ready", o_flit_ready, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check("t8_stall_ready", o_flit_ready, 1'b0);
    end
    i_payload_ready = 1'b1;
    wait_accept("t8_beat1");
    send_beat(256'h83, 32'h4, 1'b1, "t8_beat2");
    idle(2);
    check("t8_header_pending", o_header_valid, 1'b1);
    check("t8_header_length", o_length, 8'd3);
    i_header_ready = 1'b1;
    idle(3);
    check("t8_headers", hdr_seen - h0, 1);
    check("t8_beats", beat_seen - b0, 3);
    check("t8_errors", err_seen - e0, 0);

    // T9: reset in the middle of a packet
    send_header(mk_hdr(8'h60, 8'h90, 8'd2, 64'h9000, 2'd0, 5'd0, 1'b0), 1'b0, "t9_hdr");
    send_beat(256'h91, 32'h1, 1'b0, "t9_beat0");
    i_flit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t9_reset_payload_valid", o_payload_valid, 1'b0);
    check("t9_reset_header_valid", o_header_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    e0 = err_seen; b0 = beat_seen;
    send_beat(256'h92, 32'h1, 1'b1, "t9_beat_after_reset");
    idle(3);
    check("t9_errors", err_seen - e0, 1);
    check("t9_beats", beat_seen - b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noc_packet_unpacker.md
Name: noc_packet_unpacker

Overview:
- Flit-to-packet receive stage at a NoC endpoint (router local port -> target/initiator adapter).
- Consumes the {flit_type, tail, data} flit stream, decodes header flits into parallel header fields, and forwards payload flits as a data/byte-enable beat stream with a last marker.
- Detects framing errors and drops malformed packets so the downstream adapter always sees well-framed packets.

Parameters:
- ID_X_WIDTH, 4, location-id x width
- ID_Y_WIDTH, 4, location-id y width
- TAG_WIDTH, 8, tag width
- LENGTH_WIDTH, 8, length field width; value 0 encodes 2^LENGTH_WIDTH beats
- ADDRESS_WIDTH, 64, request address width
- DATA_WIDTH, 256, payload data width; byte-enable width is DATA_WIDTH/8; lower-address width is clog2(DATA_WIDTH/8)
- FLIT_WIDTH, derived, 2 + max(header width, DATA_WIDTH + DATA_WIDTH/8)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_flit_valid  in  1  flit valid
- o_flit_ready  out  1  flit ready
- i_flit  in  FLIT_WIDTH  {flit_type (0=header, 1=payload), tail, data}
- o_header_valid  out  1  header valid
- i_header_ready  in  1  header ready
- o_packet_type  out  8  packet type
- o_destination_id  out  ID_X_WIDTH+ID_Y_WIDTH  destination id {x,y}
- o_source_id  out  ID_X_WIDTH+ID_Y_WIDTH  source id {x,y}
- o_tag  out  TAG_WIDTH  tag
- o_length  out  LENGTH_WIDTH  length
- o_address  out  ADDRESS_WIDTH  request address; 0 for responses
- o_response_status  out  2  response status; 0 for requests
- o_lower_address  out  clog2(DATA_WIDTH/8)  response lower address
- o_last_response  out  1  response last flag
- o_payload_valid  out  1  payload beat valid
- i_payload_ready  in  1  payload beat ready
- o_data  out  DATA_WIDTH  payload data
- o_byte_enable  out  DATA_WIDTH/8  payload byte enables
- o_payload_last  out  1  last payload beat of the packet
- o_error  out  1  one-cycle framing-error pulse

Behaviour:
- Clock and reset: clk only; rst is asynchronous and active-high.
- Reset: all valids, o_error, o_payload_last, all registered fields = 0; FSM = IDLE; beat counter = 0.
- Flit data layout:
  - Flit data is LSB-aligned.
  - Payload data field = {data, byte_enable}.
  - Common header = {packet_type, destination_id, source_id, tag, length}, packet_type at the MSB end.
  - Request header = {common, address}.
  - Response header (packet_type[7]=1) = {common, status, lower_address, last_response}.
- has_payload = packet_type[6]: POSTED_WRITE 0x40, NON_POSTED_WRITE 0x60, RESPONSE_WITH_DATA 0xC0.
- Output registers: header and payload outputs each have one register stage; latency 1 cycle from flit acceptance.
- Output handshake: a valid output holds all its fields stable until ready is seen.
- o_flit_ready:
  - Header flit in IDLE: !o_header_valid | i_header_ready.
  - Payload flit in PAYLOAD: !o_payload_valid | i_payload_ready.
  - Every dropped flit: 1.
  - o_flit_ready may depend on i_flit.flit_type.
- FSM IDLE:
  - Header flit, well-formed (tail == !has_payload): load header, o_header_valid=1. Go to PAYLOAD if has_payload, else stay in IDLE.
  - Header flit, malformed: drop it and pulse o_error. Go to DROP if tail=0, else stay in IDLE.
  - Payload flit: drop it and pulse o_error.
- FSM PAYLOAD:
  - Payload flit: emit a beat with o_payload_last = tail. On tail, go to IDLE.
  - Header flit: drop it, pulse o_error, stay in PAYLOAD.
- FSM DROP: drop every flit; on tail, go to IDLE.
- Header/payload overlap: the header output may still be waiting for i_header_ready while payload beats flow; the two outputs are independent.
- Back-to-back packets: a tail beat and the next header are accepted in consecutive cycles with no bubble.
- Reset mid-packet: all state is cleared immediately; any partial packet is discarded.

Optional Feature:
- Macro: NOC_PACKET_UNPACKER_LENGTH_CHECK_EN.
- Defined:
  - Beat counter (LENGTH_WIDTH+1 bits) clears on header acceptance and increments per forwarded beat.
  - At the tail beat, if count != expected (length, 0 -> 2^LENGTH_WIDTH), pulse o_error in the cycle after the tail is accepted.
  - The payload is still forwarded unchanged.
- Not defined: no counter exists; the tail alone terminates the packet; length mismatches never raise o_error.

Decomposition:
- Shared package noc_packet_types_pkg:
  - packet-type enum and response-status enum
  - flit-type enum
  - width localparams: header widths, payload width, flit width
  - has_payload function
- Sub-module noc_packet_unpacker_slice: single-entry valid/ready register, width-parameterized, instanced twice (header and payload).
- FSM and decode stay in the top module.

Test Plan:
- NON_POSTED_WRITE header (length=2, tail=0), then payload beats 0xA (tail=0) and 0xB (tail=1) -> header fields match; beats carry last=0 then last=1; no o_error.
- READ header tail=1, address 0x1000_0040, i_header_ready held 0 for 5 cycles -> o_header_valid stays 1 with fields stable, o_flit_ready=0; next header accepted the cycle after ready.
- Payload flit in IDLE -> consumed (o_flit_ready=1), o_error pulses once, no output valid.
- POSTED_WRITE header with tail=1 -> dropped, o_error pulses, no header output; a following READ header is forwarded normally.
- Header with tail=0 on READ, then 2 payload flits (second tail=1) -> all dropped, one o_error pulse, FSM back to IDLE.
- With the macro defined: RESPONSE_WITH_DATA length=3 but tail on beat 2 -> 2 beats forwarded, o_error the cycle after the tail; without the macro -> no o_error.
